// File: rtl/mem_req_axi4lite_master.sv
// mem_req_axi4lite_master
// Bridges a simple valid/ready memory request port onto an AXI4-Lite master.
// Only one transaction is in flight at a time. Every output comes from a register.
//
// Ports
//   clk, rstn                      clock; synchronous active-low reset
//   i_req_*/o_req_ready            upstream request (cmd 1=write, 0=read)
//   o_rsp_valid/o_rsp_data/o_rsp_err
//                                  one-cycle completion pulse. Data is 0 for
//                                  writes; err is set when the AXI resp is not OKAY.
//   *_m_axi4lite_aw_*, *_w_*, *_b_*
//                                  AXI4-Lite write channels
//   *_m_axi4lite_ar_*, *_r_*       AXI4-Lite read channels
//   There are no prot outputs; the slave's aw_prot/ar_prot are tied to 3'b000.
module mem_req_axi4lite_master #(
  parameter  int unsigned ADDR_BITS = 32,
  parameter  int unsigned DATA_BITS = 64,
  localparam int unsigned STRB_BITS = DATA_BITS / 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic                 i_req_cmd,
  input  logic [ADDR_BITS-1:0] i_req_addr,
  input  logic [DATA_BITS-1:0] i_req_data,
  input  logic [STRB_BITS-1:0] i_req_strb,
  output logic                 o_rsp_valid,
  output logic [DATA_BITS-1:0] o_rsp_data,
  output logic                 o_rsp_err,
  output logic                 o_m_axi4lite_aw_valid,
  input  logic                 i_m_axi4lite_aw_ready,
  output logic [ADDR_BITS-1:0] o_m_axi4lite_aw_addr,
  output logic                 o_m_axi4lite_w_valid,
  input  logic                 i_m_axi4lite_w_ready,
  output logic [DATA_BITS-1:0] o_m_axi4lite_w_data,
  output logic [STRB_BITS-1:0] o_m_axi4lite_w_strb,
  input  logic                 i_m_axi4lite_b_valid,
  output logic                 o_m_axi4lite_b_ready,
  input  logic [1:0]           i_m_axi4lite_b_resp,
  output logic                 o_m_axi4lite_ar_valid,
  input  logic                 i_m_axi4lite_ar_ready,
  output logic [ADDR_BITS-1:0] o_m_axi4lite_ar_addr,
  input  logic                 i_m_axi4lite_r_valid,
  output logic                 o_m_axi4lite_r_ready,
  input  logic [DATA_BITS-1:0] i_m_axi4lite_r_data,
  input  logic [1:0]           i_m_axi4lite_r_resp
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t               r_state;
  logic                 r_req_ready;
  logic [ADDR_BITS-1:0] r_addr;
  logic [DATA_BITS-1:0] r_wdata;
  logic [STRB_BITS-1:0] r_strb;
  logic                 r_aw_valid;
  logic                 r_w_valid;
  logic                 r_ar_valid;
  logic                 r_b_ready;
  logic                 r_r_ready;
  logic                 r_aw_done;
  logic                 r_w_done;
  logic                 r_rsp_valid;
  logic [DATA_BITS-1:0] r_rsp_data;
  logic                 r_rsp_err;

  // Handshake decodes; the valids/readies involved are all registers.
  logic w_req_hs;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_ar_hs;
  logic w_b_hs;
  logic w_r_hs;
  logic w_aw_done_nxt;
  logic w_w_done_nxt;

  assign w_req_hs      = i_req_valid & r_req_ready;
  assign w_aw_hs       = r_aw_valid & i_m_axi4lite_aw_ready;
  assign w_w_hs        = r_w_valid & i_m_axi4lite_w_ready;
  assign w_ar_hs       = r_ar_valid & i_m_axi4lite_ar_ready;
  assign w_b_hs        = r_b_ready & i_m_axi4lite_b_valid;
  assign w_r_hs        = r_r_ready & i_m_axi4lite_r_valid;
  // A channel counts as done if it finished earlier or finishes this cycle.
  assign w_aw_done_nxt = r_aw_done | w_aw_hs;
  assign w_w_done_nxt  = r_w_done | w_w_hs;

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b1;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_strb      <= '0;
      r_aw_valid  <= 1'b0;
      r_w_valid   <= 1'b0;
      r_ar_valid  <= 1'b0;
      r_b_ready   <= 1'b0;
      r_r_ready   <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req_hs) begin
            r_req_ready <= 1'b0;
            r_addr      <= i_req_addr;
            r_wdata     <= i_req_data;
            r_strb      <= i_req_strb;
            if (i_req_cmd) begin
              r_state    <= WR_REQ;
              r_aw_valid <= 1'b1;
              r_w_valid  <= 1'b1;
            end else begin
              r_state    <= RD_REQ;
              r_ar_valid <= 1'b1;
            end
          end
        end
        WR_REQ: begin
          // AW and W complete independently; each valid drops after its own handshake.
          if (w_aw_hs) begin
            r_aw_valid <= 1'b0;
            r_aw_done  <= 1'b1;
          end
          if (w_w_hs) begin
            r_w_valid <= 1'b0;
            r_w_done  <= 1'b1;
          end
          if (w_aw_done_nxt && w_w_done_nxt) begin
            r_state   <= WR_RESP;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_b_ready <= 1'b1;
          end
        end
        WR_RESP: begin
          if (w_b_hs) begin
            r_state     <= RSP;
            r_b_ready   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= '0;
            r_rsp_err   <= (i_m_axi4lite_b_resp != 2'b00);
          end
        end
        RD_REQ: begin
          if (w_ar_hs) begin
            r_state    <= RD_RESP;
            r_ar_valid <= 1'b0;
            r_r_ready  <= 1'b1;
          end
        end
        RD_RESP: begin
          if (w_r_hs) begin
            r_state     <= RSP;
            r_r_ready   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= i_m_axi4lite_r_data;
            r_rsp_err   <= (i_m_axi4lite_r_resp != 2'b00);
          end
        end
        RSP: begin
          r_state     <= IDLE;
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_req_ready           = r_req_ready;
  assign o_rsp_valid           = r_rsp_valid;
  assign o_rsp_data            = r_rsp_data;
  assign o_rsp_err             = r_rsp_err;
  assign o_m_axi4lite_aw_valid = r_aw_valid;
  assign o_m_axi4lite_aw_addr  = r_addr;
  assign o_m_axi4lite_w_valid  = r_w_valid;
  assign o_m_axi4lite_w_data   = r_wdata;
  assign o_m_axi4lite_w_strb   = r_strb;
  assign o_m_axi4lite_b_ready  = r_b_ready;
  assign o_m_axi4lite_ar_valid = r_ar_valid;
  assign o_m_axi4lite_ar_addr  = r_addr;
  assign o_m_axi4lite_r_ready  = r_r_ready;

endmodule

// File: tb/tb_mem_req_axi4lite_master.sv
// Testbench for mem_req_axi4lite_master. It contains a configurable AXI4-Lite
// memory slave, a protocol monitor and a byte-lane memory reference model.
module tb_mem_req_axi4lite_master;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_cmd = 1'b0;
  logic [31:0] i_req_addr = '0;
  logic [63:0] i_req_data = '0;
  logic [7:0]  i_req_strb = '0;
  logic        o_rsp_valid;
  logic [63:0] o_rsp_data;
  logic        o_rsp_err;
  logic        o_aw_valid, o_w_valid, o_ar_valid, o_b_ready, o_r_ready;
  logic [31:0] o_aw_addr, o_ar_addr;
  logic [63:0] o_w_data;
  logic [7:0]  o_w_strb;

  // Slave-side drive
  logic        aw_rdy = 1'b0, w_rdy = 1'b0, ar_rdy = 1'b0;
  logic        b_vld = 1'b0, r_vld = 1'b0;
  logic [1:0]  b_rsp = 2'b00, r_rsp = 2'b00;
  logic [63:0] r_dat = '0;

  always #5 clk = ~clk;

  mem_req_axi4lite_master dut (
    .clk                   (clk),
    .rstn                  (rstn),
    .i_req_valid           (i_req_valid),
    .o_req_ready           (o_req_ready),
    .i_req_cmd             (i_req_cmd),
    .i_req_addr            (i_req_addr),
    .i_req_data            (i_req_data),
    .i_req_strb            (i_req_strb),
    .o_rsp_valid           (o_rsp_valid),
    .o_rsp_data            (o_rsp_data),
    .o_rsp_err             (o_rsp_err),
    .o_m_axi4lite_aw_valid (o_aw_valid),
    .i_m_axi4lite_aw_ready (aw_rdy),
    .o_m_axi4lite_aw_addr  (o_aw_addr),
    .o_m_axi4lite_w_valid  (o_w_valid),
    .i_m_axi4lite_w_ready  (w_rdy),
    .o_m_axi4lite_w_data   (o_w_data),
    .o_m_axi4lite_w_strb   (o_w_strb),
    .i_m_axi4lite_b_valid  (b_vld),
    .o_m_axi4lite_b_ready  (o_b_ready),
    .i_m_axi4lite_b_resp   (b_rsp),
    .o_m_axi4lite_ar_valid (o_ar_valid),
    .i_m_axi4lite_ar_ready (ar_rdy),
    .o_m_axi4lite_ar_addr  (o_ar_addr),
    .i_m_axi4lite_r_valid  (r_vld),
    .o_m_axi4lite_r_ready  (o_r_ready),
    .i_m_axi4lite_r_data   (r_dat),
    .i_m_axi4lite_r_resp   (r_rsp)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic rst_seen = 1'b0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rstn;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Slave configuration, written by the stimulus
  int        cfg_aw_hold = 0, cfg_w_hold = 0, cfg_ar_hold = 0;
  int        cfg_b_lat = 0, cfg_r_lat = 0;
  bit        cfg_rand = 1'b0;
  logic [1:0] cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  int        clr_req = 0;

  // Slave state and statistics
  int          clr_seen = 0;
  int          aw_seen = 0, w_seen = 0, ar_seen = 0;
  logic [31:0] aw_q[$];
  logic [63:0] wd_q[$];
  logic [7:0]  ws_q[$];
  bit          b_pend = 0, r_pend = 0, b_fire = 0, r_fire = 0;
  int          b_wait = 0, r_wait = 0;
  logic [31:0] r_addr_q = '0;
  logic [63:0] smem [logic [31:0]];
  int          aw_vcyc = 0, w_vcyc = 0, n_ar = 0;
  int          last_aw_pe = 0, last_w_pe = 0, last_ar_pe = 0, last_b_pe = 0, last_r_pe = 0;

  // Values from the previous falling edge, used by the protocol monitor
  logic        p_aw_v = 0, p_w_v = 0, p_ar_v = 0, p_aw_r = 0, p_w_r = 0, p_ar_r = 0;
  logic        p_b_rdy = 0, p_r_rdy = 0, p_b_v = 0, p_r_v = 0, p_rsp_v = 0;
  logic [31:0] p_aw_a = '0, p_ar_a = '0;
  logic [63:0] p_w_d = '0;
  logic [7:0]  p_w_s = '0;

  // Slave model plus protocol monitor. Everything happens on the falling edge.
  always @(negedge clk) begin
    if (clr_req != clr_seen) begin
      clr_seen = clr_req;
      aw_rdy = 0; w_rdy = 0; ar_rdy = 0; b_vld = 0; r_vld = 0;
      aw_q.delete(); wd_q.delete(); ws_q.delete();
      b_pend = 0; r_pend = 0; b_fire = 0; r_fire = 0;
      aw_seen = 0; w_seen = 0; ar_seen = 0;
    end else begin
      // Protocol monitor: the previous cycle's ready/valid are still on the wires here
      if (rst_seen) begin
        if (p_aw_v && !p_aw_r) begin
          chk("aw_valid_hold", 64'(o_aw_valid), 64'd1);
          chk("aw_addr_stable", 64'(o_aw_addr), 64'(p_aw_a));
        end
        if (p_w_v && !p_w_r) begin
          chk("w_valid_hold", 64'(o_w_valid), 64'd1);
          chk("w_data_stable", o_w_data, p_w_d);
          chk("w_strb_stable", 64'(o_w_strb), 64'(p_w_s));
        end
        if (p_ar_v && !p_ar_r) begin
          chk("ar_valid_hold", 64'(o_ar_valid), 64'd1);
          chk("ar_addr_stable", 64'(o_ar_addr), 64'(p_ar_a));
        end
        if (p_b_rdy && !p_b_v) chk("b_ready_hold", 64'(o_b_ready), 64'd1);
        if (p_r_rdy && !p_r_v) chk("r_ready_hold", 64'(o_r_ready), 64'd1);
        if (p_rsp_v) chk("rsp_single_pulse", 64'(o_rsp_valid), 64'd0);
        if (o_req_ready)
          chk("req_ready_only_idle",
              64'({o_aw_valid, o_w_valid, o_ar_valid, o_b_ready, o_r_ready, o_rsp_valid}), 64'd0);
        if (o_b_ready) chk("b_ready_after_aw_w", 64'({o_aw_valid, o_w_valid}), 64'd0);
      end

      if (b_fire) begin b_vld = 0; b_fire = 0; end
      if (r_fire) begin r_vld = 0; r_fire = 0; end
      if (o_aw_valid) aw_vcyc++;
      if (o_w_valid) w_vcyc++;

      aw_rdy = (aw_seen >= cfg_aw_hold) && (!cfg_rand || $urandom_range(0, 1) == 1);
      w_rdy  = (w_seen  >= cfg_w_hold)  && (!cfg_rand || $urandom_range(0, 1) == 1);
      ar_rdy = (ar_seen >= cfg_ar_hold) && (!cfg_rand || $urandom_range(0, 1) == 1);

      if (o_aw_valid && aw_rdy) begin
        aw_q.push_back(o_aw_addr); last_aw_pe = cyc + 1; aw_seen = 0;
      end else if (o_aw_valid) aw_seen++;
      if (o_w_valid && w_rdy) begin
        wd_q.push_back(o_w_data); ws_q.push_back(o_w_strb); last_w_pe = cyc + 1; w_seen = 0;
      end else if (o_w_valid) w_seen++;

      // Response channels; a response only appears on an edge after its request is captured
      if (b_pend && !b_vld) begin
        if (b_wait == 0) begin b_vld = 1; b_rsp = cfg_bresp; b_pend = 0; end
        else b_wait--;
      end
      if (r_pend && !r_vld) begin
        if (r_wait == 0) begin
          r_vld = 1; r_rsp = cfg_rresp; r_pend = 0;
          r_dat = smem.exists(r_addr_q) ? smem[r_addr_q] : 64'd0;
        end else r_wait--;
      end
      if (b_vld && o_b_ready) begin b_fire = 1; last_b_pe = cyc + 1; end
      if (r_vld && o_r_ready) begin r_fire = 1; last_r_pe = cyc + 1; end

      if (o_ar_valid && ar_rdy) begin
        n_ar++; last_ar_pe = cyc + 1; ar_seen = 0;
        r_pend = 1; r_wait = cfg_r_lat; r_addr_q = o_ar_addr;
      end else if (o_ar_valid) ar_seen++;

      if (aw_q.size() > 0 && wd_q.size() > 0) begin
        logic [31:0] a;
        logic [63:0] d, m;
        logic [7:0]  s;
        a = aw_q.pop_front(); d = wd_q.pop_front(); s = ws_q.pop_front();
        m = smem.exists(a) ? smem[a] : 64'd0;
        for (int i = 0; i < 8; i++) if (s[i]) m[i*8 +: 8] = d[i*8 +: 8];
        smem[a] = m;
        b_pend = 1; b_wait = cfg_b_lat;
      end
    end
    p_aw_v = o_aw_valid; p_w_v = o_w_valid; p_ar_v = o_ar_valid;
    p_aw_r = aw_rdy; p_w_r = w_rdy; p_ar_r = ar_rdy;
    p_b_rdy = o_b_ready; p_r_rdy = o_r_ready; p_b_v = b_vld; p_r_v = r_vld;
    p_rsp_v = o_rsp_valid;
    p_aw_a = o_aw_addr; p_ar_a = o_ar_addr; p_w_d = o_w_data; p_w_s = o_w_strb;
  end

  // Watchdog
  always @(negedge clk) begin
    if (cyc > 60000) begin
      $display("FAIL watchdog observed=%0d cycles expected=<60000", cyc);
      $fatal(1, "watchdog");
    end
  end

  // Reference model: expected memory contents after applying byte-enabled writes
  logic [63:0] exp_mem [logic [31:0]];
  int fire_pe = 0;

  function automatic logic [63:0] model_read(input logic [31:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : 64'd0;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
    logic [63:0] bytes_keep;
    bytes_keep = 64'd0;
    for (int i = 0; i < 8; i++) bytes_keep[i*8 +: 8] = s[i] ? 8'h00 : 8'hFF;
    exp_mem[a] = (model_read(a) & bytes_keep) | (d & ~bytes_keep);
  endfunction

  // Presents one request, waits for acceptance, then withdraws it.
  task automatic issue(input logic cmd, input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
    int n;
    n = 0;
    @(negedge clk);
    i_req_valid = 1; i_req_cmd = cmd; i_req_addr = a; i_req_data = d; i_req_strb = s;
    while (!o_req_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("req_accept_timeout", 64'd0, 64'd1);
    fire_pe = cyc + 1;
    if (cmd) model_write(a, d, s);
    @(negedge clk);
    i_req_valid = 0;
  endtask

  // Waits for the completion pulse and checks it against the expected result.
  task automatic wait_rsp(input string tag, input logic is_wr, input logic [63:0] exp_d,
                          input logic exp_err, input bit chk_lat);
    int n;
    n = 0;
    while (!o_rsp_valid && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) chk({tag, "_rsp_timeout"}, 64'd0, 64'd1);
    else begin
      chk({tag, "_data"}, o_rsp_data, exp_d);
      chk({tag, "_err"}, 64'(o_rsp_err), 64'(exp_err));
      chk({tag, "_rsp_cycle"}, 64'(cyc), 64'(is_wr ? last_b_pe : last_r_pe));
      if (chk_lat && is_wr) begin
        chk({tag, "_aw_latency"}, 64'(last_aw_pe), 64'(fire_pe + 1));
        chk({tag, "_w_latency"}, 64'(last_w_pe), 64'(fire_pe + 1));
      end
      if (chk_lat && !is_wr) chk({tag, "_ar_latency"}, 64'(last_ar_pe), 64'(fire_pe + 1));
      @(negedge clk);
      chk({tag, "_rsp_low_after"}, 64'(o_rsp_valid), 64'd0);
    end
  endtask

  initial begin
    int a0, w0, n, fires, rsps, last_rsp;
    logic [31:0] ba [3];
    logic [63:0] bd [3];
    logic        cmd;
    logic [31:0] a;
    logic [63:0] d;
    logic [7:0]  s;
    logic [1:0]  rr;

    // Reset values
    rstn = 0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(o_req_ready), 64'd1);
    chk("rst_valids", 64'({o_aw_valid, o_w_valid, o_ar_valid}), 64'd0);
    chk("rst_readies", 64'({o_b_ready, o_r_ready}), 64'd0);
    chk("rst_rsp", 64'({o_rsp_valid, o_rsp_err}), 64'd0);
    chk("rst_rsp_data", o_rsp_data, 64'd0);
    rstn = 1;
    @(negedge clk);

    // Zero-wait write then read-back
    issue(1'b1, 32'h100, 64'h1122334455667788, 8'hFF);
    wait_rsp("wr100", 1'b1, 64'd0, 1'b0, 1'b1);
    a0 = n_ar;
    issue(1'b0, 32'h100, 64'd0, 8'h00);
    wait_rsp("rd100", 1'b0, model_read(32'h100), 1'b0, 1'b1);
    chk("rd100_data_const", o_rsp_data, 64'h1122334455667788);
    chk("rd100_single_ar", 64'(n_ar - a0), 64'd1);

    // Slow AW, immediate W
    cfg_aw_hold = 3; cfg_b_lat = 2;
    a0 = aw_vcyc; w0 = w_vcyc;
    issue(1'b1, 32'h180, 64'hCAFEF00DDEADBEEF, 8'h0F);
    wait_rsp("wr_slow_aw", 1'b1, 64'd0, 1'b0, 1'b0);
    chk("slow_aw_w_cycles", 64'(w_vcyc - w0), 64'd1);
    chk("slow_aw_aw_cycles", 64'(aw_vcyc - a0), 64'd4);
    chk("slow_aw_b_after_aw", 64'(last_b_pe > last_aw_pe), 64'd1);
    cfg_aw_hold = 0; cfg_b_lat = 0;
    issue(1'b0, 32'h180, 64'd0, 8'h00);
    wait_rsp("rd180", 1'b0, model_read(32'h180), 1'b0, 1'b1);

    // Slave error on a write
    cfg_bresp = 2'b10;
    issue(1'b1, 32'h108, 64'h0123456789ABCDEF, 8'hF0);
    wait_rsp("wr_slverr", 1'b1, 64'd0, 1'b1, 1'b1);
    cfg_bresp = 2'b00;

    // Reset while waiting for R
    cfg_r_lat = 100000;
    issue(1'b0, 32'h100, 64'd0, 8'h00);
    n = 0;
    while (!o_r_ready && n < 50) begin @(negedge clk); n++; end
    chk("rd_resp_reached", 64'(o_r_ready), 64'd1);
    rstn = 0;
    @(negedge clk);
    chk("midrst_ar_r", 64'({o_ar_valid, o_r_ready}), 64'd0);
    chk("midrst_rsp_valid", 64'(o_rsp_valid), 64'd0);
    chk("midrst_req_ready", 64'(o_req_ready), 64'd1);
    chk("midrst_rsp_data_err", {o_rsp_data[62:0], o_rsp_err}, 64'd0);
    rstn = 1;
    clr_req++;
    cfg_r_lat = 0;
    repeat (2) @(negedge clk);
    issue(1'b1, 32'h110, 64'h5555AAAA5555AAAA, 8'hFF);
    wait_rsp("wr_after_rst", 1'b1, 64'd0, 1'b0, 1'b1);
    issue(1'b0, 32'h110, 64'd0, 8'h00);
    wait_rsp("rd_after_rst", 1'b0, model_read(32'h110), 1'b0, 1'b1);

    // req_valid held across three writes
    ba[0] = 32'h140; ba[1] = 32'h148; ba[2] = 32'h150;
    bd[0] = 64'hA0A0A0A0A0A0A0A0; bd[1] = 64'hB1B1B1B1B1B1B1B1; bd[2] = 64'hC2C2C2C2C2C2C2C2;
    fires = 0; rsps = 0; n = 0; last_rsp = -10;
    @(negedge clk);
    i_req_valid = 1; i_req_cmd = 1; i_req_addr = ba[0]; i_req_data = bd[0]; i_req_strb = 8'hFF;
    while ((fires < 3 || rsps < 3) && n < 300) begin
      if (o_rsp_valid) begin
        rsps++; last_rsp = cyc;
        chk("b2b_rsp", {o_rsp_data[62:0], o_rsp_err}, 64'd0);
      end
      if (i_req_valid && o_req_ready) begin
        if (fires > 0) chk("b2b_gap_after_rsp", 64'(cyc >= last_rsp + 1), 64'd1);
        model_write(ba[fires], bd[fires], 8'hFF);
        fires++;
        @(negedge clk); n++;
        if (fires < 3) begin i_req_addr = ba[fires]; i_req_data = bd[fires]; end
        else i_req_valid = 0;
      end else begin
        @(negedge clk); n++;
      end
    end
    chk("b2b_fires", 64'(fires), 64'd3);
    chk("b2b_rsps", 64'(rsps), 64'd3);
    i_req_valid = 0;
    for (int k = 0; k < 3; k++) begin
      issue(1'b0, ba[k], 64'd0, 8'h00);
      wait_rsp("b2b_readback", 1'b0, model_read(ba[k]), 1'b0, 1'b1);
    end

    // Random traffic with random slave stalls, latencies and responses
    for (int k = 0; k < 60; k++) begin
      cfg_rand = 1'b1;
      cfg_aw_hold = $urandom_range(0, 3);
      cfg_w_hold = $urandom_range(0, 3);
      cfg_ar_hold = $urandom_range(0, 3);
      cfg_b_lat = $urandom_range(0, 4);
      cfg_r_lat = $urandom_range(0, 4);
      rr = 2'($urandom_range(0, 3));
      cfg_bresp = ($urandom_range(0, 3) == 0) ? rr : 2'b00;
      cfg_rresp = ($urandom_range(0, 3) == 0) ? rr : 2'b00;
      cmd = 1'($urandom_range(0, 1));
      a = 32'h200 + 32'($urandom_range(0, 7)) * 32'd8;
      d = {$urandom, $urandom};
      s = 8'($urandom);
      if (cmd) begin
        issue(1'b1, a, d, s);
        wait_rsp("rnd_wr", 1'b1, 64'd0, cfg_bresp != 2'b00, 1'b0);
      end else begin
        logic [63:0] e;
        e = model_read(a);
        issue(1'b0, a, 64'd0, 8'h00);
        wait_rsp("rnd_rd", 1'b0, e, cfg_rresp != 2'b00, 1'b0);
      end
    end
    cfg_rand = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_req_axi4lite_master.md
MEM_REQ_AXI4LITE_MASTER -- requirements
Module: mem_req_axi4lite_master

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 32, AXI4-Lite and request address width; STRB width SHALL be DATA_BITS/8.
REQ-002 SHALL have parameter DATA_BITS, default 64, AXI4-Lite and request data width.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 rstn  in  1  reset: synchronous, active-low.
REQ-005 req_valid  in  1  upstream request valid.
REQ-006 req_ready  out  1  request accepted this cycle.
REQ-007 req_cmd  in  1  0 = read, 1 = write.
REQ-008 req_addr  in  ADDR_BITS  byte address.
REQ-009 req_data  in  DATA_BITS  write data.
REQ-010 req_strb  in  STRB  write byte enables.
REQ-011 rsp_valid  out  1  one-cycle completion pulse.
REQ-012 rsp_data  out  DATA_BITS  read data; 0 for writes.
REQ-013 rsp_err  out  1  AXI resp was not OKAY.
REQ-014 m_axi4lite_aw_valid / aw_ready / aw_addr  out / in / out  1 / 1 / ADDR_BITS  write address channel.
REQ-015 m_axi4lite_w_valid / w_ready  out / in  1 / 1  write data handshake.
REQ-016 m_axi4lite_w_data / w_strb  out  DATA_BITS / STRB  write payload.
REQ-017 m_axi4lite_b_valid / b_ready / b_resp  in / out / in  1 / 1 / 2  write response channel.
REQ-018 m_axi4lite_ar_valid / ar_ready / ar_addr  out / in / out  1 / 1 / ADDR_BITS  read address channel.
REQ-019 m_axi4lite_r_valid / r_ready  in / out  1 / 1  read data handshake.
REQ-020 m_axi4lite_r_data / r_resp  in  DATA_BITS / 2  read payload.
REQ-021 SHALL NOT generate prot; integrator SHALL tie slave aw_prot/ar_prot to 3'b000.

Function
REQ-022 SHALL implement states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP; exactly one transaction outstanding.
REQ-023 req_ready SHALL be 1 only in IDLE. On req_valid&req_ready, SHALL register cmd/addr/data/strb and go to WR_REQ (cmd=1) or RD_REQ (cmd=0).
REQ-024 WR_REQ: aw_valid and w_valid SHALL both rise on entry. Each SHALL drop the cycle after its own handshake, tracked by flags aw_done/w_done. Handshakes may occur in the same or different cycles, in either order.
REQ-025 SHALL go to WR_RESP the cycle after both aw_done and w_done are set. Flags SHALL clear on entry to WR_RESP.
REQ-026 WR_RESP: b_ready=1. On b_valid SHALL latch b_resp, go to RSP.
REQ-027 RD_REQ: ar_valid=1 until ar_ready; then go to RD_RESP.
REQ-028 RD_RESP: r_ready=1. On r_valid SHALL latch r_data and r_resp, go to RSP.
REQ-029 RSP: rsp_valid=1 for exactly one cycle, then IDLE.
- rsp_err = (latched resp != 2'b00).
- rsp_data = latched r_data for reads, 0 for writes.
- rsp_valid SHALL be asserted the cycle after the B or R handshake.
REQ-030 AXI valids SHALL depend only on registered state, never combinationally on ready.
- Once asserted, a valid SHALL hold until handshake.
- Addr/data/strb SHALL stay stable while the corresponding valid is high.
REQ-031 b_valid/r_valid arriving outside WR_RESP/RD_RESP SHALL be ignored (ready=0). req_valid while busy SHALL be ignored (req_ready=0).
REQ-032 Zero-wait slave:
- Request fire at cycle N -> AW/W or AR handshake at N+1.
- Back-to-back request accepted no earlier than 1 cycle after rsp_valid.

Reset
REQ-033 rstn=0 at any edge, including mid-transaction, SHALL force IDLE and clear flags and latched data. The next cycle SHALL have:
- all AXI valids, b_ready, r_ready, rsp_valid, rsp_err = 0; rsp_data = 0;
- req_ready = 1.

Verification
REQ-034 Write addr 0x100, data 0x1122334455667788, strb 0xFF, slave always ready -> AW and W fire at N+1, b_ready high, rsp_valid 1 cycle after B, rsp_err=0, rsp_data=0.
REQ-035 Read back 0x100 -> single AR handshake, rsp_data=0x1122334455667788, rsp_err=0.
REQ-036 aw_ready held low 3 cycles, w_ready immediate -> w_valid drops after 1 cycle, aw_valid held with stable addr until handshake, WR_RESP only after both.
REQ-037 b_resp=2'b10 (SLVERR) -> rsp_err=1 for the single rsp_valid cycle.
REQ-038 rstn low during RD_RESP -> next cycle ar_valid=r_ready=rsp_valid=0, req_ready=1; a new write then completes normally.
REQ-039 req_valid held high over 3 writes -> exactly 3 req handshakes, each only in IDLE, 3 rsp_valid pulses.
